// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning the MIPS HI/LO pair, with a start/busy/done handshake.
// Define MIPS_MULDIV_MADD_EN to add the MADD/MADDU accumulate ops (op 110/111).
module mips_muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] acc_q;       // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   opd_q;       // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   dividend_q;
   logic               is_div_q;
   logic               neg_lo_q;
   logic               neg_hi_q;
   logic               dbz_q;
`ifdef MIPS_MULDIV_MADD_EN
   logic               madd_q;
   logic               go_madd;
`endif

   logic               go_mul;
   logic               go_div;
   logic               go_mthi;
   logic               go_mtlo;
   logic               signed_op;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_rem_sh;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Accept decode; busy mirrors state_q != StIdle so this is the only acceptance window.
   always_comb begin
      go_mul  = 1'b0;
      go_div  = 1'b0;
      go_mthi = 1'b0;
      go_mtlo = 1'b0;
`ifdef MIPS_MULDIV_MADD_EN
      go_madd = 1'b0;
`endif
      if (start && !busy) begin
         case (op)
            3'b000, 3'b001: go_mul  = 1'b1;
            3'b010, 3'b011: go_div  = 1'b1;
            3'b100:         go_mthi = 1'b1;
            3'b101:         go_mtlo = 1'b1;
`ifdef MIPS_MULDIV_MADD_EN
            3'b110, 3'b111: begin
               go_mul  = 1'b1;
               go_madd = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      signed_op = ~op[0];
      mag_a     = (signed_op && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
      mag_b     = (signed_op && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

      // Shift-add: add multiplicand to the upper half when the current multiplier bit is set.
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};

      // Restoring step: the remainder never exceeds the divisor, so a borrow shows in bit WIDTH.
      div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff   = div_rem_sh - {1'b0, opd_q};
      if (!div_diff[WIDTH]) begin
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end

      prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
      quot_fix = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      rem_fix  = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         acc_q       <= '0;
         opd_q       <= '0;
         dividend_q  <= '0;
         is_div_q    <= 1'b0;
         neg_lo_q    <= 1'b0;
         neg_hi_q    <= 1'b0;
         dbz_q       <= 1'b0;
`ifdef MIPS_MULDIV_MADD_EN
         madd_q      <= 1'b0;
`endif
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (go_mul || go_div || go_mthi || go_mtlo) begin
                  div_by_zero <= 1'b0;
               end
               if (go_mthi) begin
                  hi <= src_a;
               end
               if (go_mtlo) begin
                  lo <= src_a;
               end
               if (go_mul) begin
                  acc_q    <= {{WIDTH{1'b0}}, mag_b};
                  opd_q    <= mag_a;
                  neg_lo_q <= signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  neg_hi_q <= 1'b0;
                  is_div_q <= 1'b0;
                  dbz_q    <= 1'b0;
`ifdef MIPS_MULDIV_MADD_EN
                  madd_q   <= go_madd;
`endif
                  cnt_q    <= '0;
                  busy     <= 1'b1;
                  state_q  <= StMul;
               end
               if (go_div) begin
                  acc_q      <= {{WIDTH{1'b0}}, mag_a};
                  opd_q      <= mag_b;
                  dividend_q <= src_a;
                  neg_lo_q   <= signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  neg_hi_q   <= signed_op & src_a[WIDTH-1];
                  is_div_q   <= 1'b1;
                  dbz_q      <= (src_b == '0);
`ifdef MIPS_MULDIV_MADD_EN
                  madd_q     <= 1'b0;
`endif
                  cnt_q      <= '0;
                  busy       <= 1'b1;
                  state_q    <= StDiv;
               end
            end
            StMul: begin
               acc_q <= mul_next;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastIter) begin
                  state_q <= StFix;
               end
            end
            StDiv: begin
               acc_q <= div_next;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastIter) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               if (is_div_q) begin
                  if (dbz_q) begin
                     lo          <= '1;
                     hi          <= dividend_q;
                     div_by_zero <= 1'b1;
                  end else begin
                     lo <= quot_fix;
                     hi <= rem_fix;
                  end
               end else begin
`ifdef MIPS_MULDIV_MADD_EN
                  {hi, lo} <= madd_q ? ({hi, lo} + prod_fix) : prod_fix;
`else
                  {hi, lo} <= prod_fix;
`endif
               end
               cnt_q   <= '0;
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: directed ops push expected HI/LO, a monitor checks on done.
module tb_mips_muldiv_unit;

   localparam int unsigned W = 32;
   localparam int unsigned ExpBusy = W + 1;

   logic         clk;
   logic         reset;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] src_a;
   logic [W-1:0] src_b;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   mips_muldiv_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .src_a       (src_a),
      .src_b       (src_b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      string        name;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   done_seen = 0;
   int   busy_cnt  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: counts busy cycles and checks each done pulse against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            busy_cnt = 0;
         end else begin
            if (busy) busy_cnt++;
            if (done) begin
               done_seen++;
               if (sb_q.size() == 0) begin
                  check("unexpected_done", 64'(done), 64'd0);
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                  check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                  check({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
                  check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(ExpBusy));
               end
               busy_cnt = 0;
            end
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #1;
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input string name);
      for (int i = 0; i < 200 && done_seen < target; i++) @(negedge clk);
      @(negedge clk);
      check({name, "_done_arrived"}, 64'(done_seen >= target), 64'd1);
   endtask

   task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic ed);
      int target;
      sb_q.push_back('{hi: eh, lo: el, dbz: ed, name: name});
      target = done_seen + 1;
      issue(o, a, b);
      wait_done(target, name);
   endtask

   initial begin
      int d0;
      reset = 1'b1;
      start = 1'b0;
      op    = '0;
      src_a = '0;
      src_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_hi", 64'(hi), 64'd0);
      check("reset_lo", 64'(lo), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_dbz", 64'(div_by_zero), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // MTHI then MTLO back-to-back; neither raises busy.
      @(posedge clk); #1;
      start = 1'b1; op = 3'b100; src_a = 32'hDEADBEEF;
      @(posedge clk); #1;
      op = 3'b101; src_a = 32'h12345678;
      @(negedge clk);
      check("mthi_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("mtlo_busy", 64'(busy), 64'd0);
      check("mt_hi", 64'(hi), 64'hDEADBEEF);
      check("mt_lo", 64'(lo), 64'h12345678);

      run_op("mult_neg", 3'b000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
      run_op("multu", 3'b001, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 1'b0);
      run_op("mult_minmin", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
      run_op("multu_max", 3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h1, 1'b0);
      run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op("div_negdivisor", 3'b010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
      run_op("divu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
      run_op("divu_zero", 3'b011, 32'h55, 32'h0, 32'h55, 32'hFFFFFFFF, 1'b1);

      issue(3'b101, 32'h0000ABCD, 32'h0);
      @(negedge clk);
      check("mtlo_clears_dbz", 64'(div_by_zero), 64'd0);
      check("mtlo_lo", 64'(lo), 64'h0000ABCD);
      check("mtlo_keeps_hi", 64'(hi), 64'h55);

      run_op("div_zero_signed", 3'b010, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);

      // MTHI while busy must be ignored.
      sb_q.push_back('{hi: 32'h0, lo: 32'd15, dbz: 1'b0, name: "multu_ignore_start"});
      d0 = done_seen + 1;
      issue(3'b001, 32'd3, 32'd5);
      repeat (3) @(posedge clk);
      #1; start = 1'b1; op = 3'b100; src_a = 32'h00000999;
      @(posedge clk); #1; start = 1'b0;
      wait_done(d0, "multu_ignore_start");

      // Reset mid-MULT aborts; MTHI at cycle 5 ignored; no done afterwards.
      d0 = done_seen;
      issue(3'b000, 32'h1234, 32'h5678);
      repeat (4) @(posedge clk);
      #1; start = 1'b1; op = 3'b100; src_a = 32'hCAFEF00D;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      repeat (45) @(negedge clk);
      check("abort_no_done", 64'(done_seen), 64'(d0));
      check("abort_hi_late", 64'(hi), 64'd0);

      issue(3'b100, 32'h0, 32'h0);
      issue(3'b101, 32'hFFFFFFFF, 32'h0);
`ifdef MIPS_MULDIV_MADD_EN
      run_op("maddu", 3'b111, 32'd1, 32'd1, 32'd1, 32'd0, 1'b0);
      issue(3'b100, 32'h0, 32'h0);
      issue(3'b101, 32'd5, 32'h0);
      run_op("madd_neg", 3'b110, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
`else
      d0 = done_seen;
      issue(3'b111, 32'd1, 32'd1);
      @(negedge clk);
      check("maddu_off_busy", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);
      check("maddu_off_no_done", 64'(done_seen), 64'(d0));
      check("maddu_off_hi", 64'(hi), 64'd0);
      check("maddu_off_lo", 64'(lo), 64'hFFFFFFFF);
`endif
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "bench timeout");
   end

endmodule
